// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and a
// reference stage payload layout at the default operand/tag widths.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    localparam int DATA_W    = 32;
    localparam int SA_W      = $clog2(DATA_W);
    localparam int TAG_W_DEF = 4;

    // Everything that travels with an operation between pipeline registers.
    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [SA_W-1:0]      sa;
        sh_op_e               op;
        logic [TAG_W_DEF-1:0] tag;
    } sh_stage_t;

endpackage

// File: rtl/shift_level.sv
// One logarithmic shift level with an optional valid/ready output register.
// Defining SHIFTER_ROTATE_EN adds the rotate-right datapath for op 2'b11.
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SAW    = 5,
    parameter int AMT    = 16,
    parameter int SA_BIT = 4,
    parameter int TAG_W  = 4,
    parameter bit REG    = 1'b0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SAW-1:0]   in_sa,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SAW-1:0]   out_sa,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        if (in_sa[SA_BIT]) begin
            case (sh_op_e'(in_op))
                SH_SLL:  shifted = in_data << AMT;
                SH_SRA:  shifted = $signed(in_data) >>> AMT;
`ifdef SHIFTER_ROTATE_EN
                SH_ROR:  shifted = (in_data >> AMT) | (in_data << (WIDTH - AMT));
`endif
                default: shifted = in_data >> AMT;
            endcase
        end
    end

    if (REG) begin : g_reg
        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic [SAW-1:0]   sa_q;
        logic [1:0]       op_q;
        logic [TAG_W-1:0] tag_q;

        assign in_ready = !valid_q || out_ready;

        // Flush wins over a simultaneous load; payload only moves on a real transfer.
        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                sa_q    <= '0;
                op_q    <= '0;
                tag_q   <= '0;
            end else begin
                if (flush) begin
                    valid_q <= 1'b0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                end
                if (in_ready && in_valid) begin
                    data_q <= shifted;
                    sa_q   <= in_sa;
                    op_q   <= in_op;
                    tag_q  <= in_tag;
                end
            end
        end

        assign out_valid = valid_q;
        assign out_data  = data_q;
        assign out_sa    = sa_q;
        assign out_op    = op_q;
        assign out_tag   = tag_q;
        assign busy      = valid_q;
    end else begin : g_comb
        logic unused_ctl;

        assign in_ready   = out_ready;
        assign out_valid  = in_valid;
        assign out_data   = shifted;
        assign out_sa     = in_sa;
        assign out_op     = in_op;
        assign out_tag    = in_tag;
        assign busy       = 1'b0;
        assign unused_ctl = &{1'b0, clk, clrn, flush};
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined log barrel shifter (SLL/SRL/SRA, plus ROR when SHIFTER_ROTATE_EN
// is defined); REG_MASK bit k places a register after level k.
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int             WIDTH    = 32,
    parameter int             SAW      = $clog2(WIDTH),
    parameter logic [SAW-1:0] REG_MASK = SAW'(5'b00101),
    parameter int             TAG_W    = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [SAW-1:0]   in_sa,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sh,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    // Level 0 shifts by WIDTH/2 under the MSB of the shift amount.
    for (genvar k = 0; k < SAW; k++) begin : g_lvl
        logic             prv_vld, vld, rdy, nxt_rdy, bsy, bsy_acc;
        logic [WIDTH-1:0] prv_dat, dat;
        logic [SAW-1:0]   prv_sa, sa;
        logic [1:0]       prv_op, op;
        logic [TAG_W-1:0] prv_tag, tag;

        if (k == 0) begin : g_src
            assign prv_vld = in_valid;
            assign prv_dat = in_x;
            assign prv_sa  = in_sa;
            assign prv_op  = in_op;
            assign prv_tag = in_tag;
            assign bsy_acc = bsy;
        end else begin : g_src
            assign prv_vld = g_lvl[k-1].vld;
            assign prv_dat = g_lvl[k-1].dat;
            assign prv_sa  = g_lvl[k-1].sa;
            assign prv_op  = g_lvl[k-1].op;
            assign prv_tag = g_lvl[k-1].tag;
            assign bsy_acc = bsy | g_lvl[k-1].bsy_acc;
        end

        if (k == SAW - 1) begin : g_dst
            assign nxt_rdy = out_ready;
        end else begin : g_dst
            assign nxt_rdy = g_lvl[k+1].rdy;
        end

        shift_level #(
            .WIDTH (WIDTH),
            .SAW   (SAW),
            .AMT   (WIDTH >> (k + 1)),
            .SA_BIT(SAW - 1 - k),
            .TAG_W (TAG_W),
            .REG   (REG_MASK[k])
        ) u_level (
            .clk      (clk),
            .clrn     (clrn),
            .flush    (flush),
            .in_valid (prv_vld),
            .in_ready (rdy),
            .in_data  (prv_dat),
            .in_sa    (prv_sa),
            .in_op    (prv_op),
            .in_tag   (prv_tag),
            .out_valid(vld),
            .out_ready(nxt_rdy),
            .out_data (dat),
            .out_sa   (sa),
            .out_op   (op),
            .out_tag  (tag),
            .busy     (bsy)
        );
    end

    logic unused_tail;

    assign in_ready    = g_lvl[0].rdy;
    assign out_valid   = g_lvl[SAW-1].vld;
    assign out_sh      = g_lvl[SAW-1].dat;
    assign out_tag     = g_lvl[SAW-1].tag;
    assign busy        = g_lvl[SAW-1].bsy_acc;
    assign unused_tail = &{1'b0, g_lvl[SAW-1].sa, g_lvl[SAW-1].op};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed bench for pipe_barrel_shifter: default 32-bit pipeline plus a
// combinational 64-bit instance checked against a direct-shift model.
module tb_pipe_barrel_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [4:0]  in_sa = '0;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sh;
    logic [3:0]  out_tag;
    logic        busy;

    logic        w_flush = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [63:0] w_in_x = '0;
    logic [5:0]  w_in_sa = '0;
    logic [1:0]  w_in_op = '0;
    logic [3:0]  w_in_tag = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [63:0] w_out_sh;
    logic [3:0]  w_out_tag;
    logic        w_busy;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [31:0] ROR_EXP = 32'h8000_0000;
`else
    localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    pipe_barrel_shifter #(.WIDTH(32), .REG_MASK(5'b00101), .TAG_W(4)) dut (
        .clk(clk), .clrn(clrn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_sa(in_sa),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh),
        .out_tag(out_tag), .busy(busy)
    );

    pipe_barrel_shifter #(.WIDTH(64), .REG_MASK(6'b000000), .TAG_W(4)) dut_wide (
        .clk(clk), .clrn(clrn), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_x(w_in_x), .in_sa(w_in_sa),
        .in_op(w_in_op), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sh(w_out_sh),
        .out_tag(w_out_tag), .busy(w_busy)
    );

    function automatic logic [63:0] model64(logic [63:0] x, logic [5:0] sa, logic [1:0] op);
        logic [127:0] ext;
        case (op)
            2'b00: return x << sa;
            2'b10: begin
                ext = {{64{x[63]}}, x} >> sa;
                return ext[63:0];
            end
`ifdef SHIFTER_ROTATE_EN
            2'b11: begin
                ext = {x, x} >> sa;
                return ext[63:0];
            end
`endif
            default: return x >> sa;
        endcase
    endfunction

    task automatic drive_op(logic [31:0] x, logic [4:0] sa, logic [1:0] op, logic [3:0] tag);
        in_valid = 1'b1;
        in_x     = x;
        in_sa    = sa;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (out_sh !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_sh: got %h expected 00000000", out_sh);
        end
        tests_run++;
        if (out_tag !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_tag: got %h expected 0", out_tag);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        @(posedge clk); #1 clrn = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] xs [9] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'hA5A5_1234,
                                32'h8000_0000, 32'h1234_5678, 32'hF000_000F, 32'h0000_0001,
                                32'h7FFF_FFFF};
        logic [4:0]  sas [9] = '{5'd31, 5'd31, 5'd1, 5'd0, 5'd4, 5'd8, 5'd3, 5'd1, 5'd31};
        logic [1:0]  ops [9] = '{SH_SRA, SH_SLL, SH_SRL, SH_SRA, SH_SRA, SH_SLL, SH_SRL,
                                 SH_ROR, SH_SRA};
        logic [31:0] exps [9] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'hA5A5_1234,
                                  32'hF800_0000, 32'h3456_7800, 32'h1E00_0001, ROR_EXP,
                                  32'h0000_0000};
        for (int i = 0; i < 9; i++) begin
            drive_op(xs[i], sas[i], ops[i], 4'(5 + i));
            @(posedge clk); #1 in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL basic%0d_early_valid: got %b expected 0", i, out_valid);
            end
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_sh !== exps[i] || out_tag !== 4'(5 + i)) begin
                tests_failed++;
                $display("[TB] FAIL basic%0d_result: got valid=%b sh=%h tag=%h expected valid=1 sh=%h tag=%h",
                         i, out_valid, out_sh, out_tag, exps[i], 4'(5 + i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exps [8] = '{32'h3, 32'h6, 32'hC, 32'h18, 32'h30, 32'h60, 32'hC0, 32'h180};
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive_op(32'h0000_0003, 5'(c), SH_SLL, 4'(c));
            else in_valid = 1'b0;
            @(negedge clk);
            if (c < 8) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b%0d_in_ready: got %b expected 1", c, in_ready);
                end
            end
            if (c >= 2) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_sh !== exps[c-2] || out_tag !== 4'(c - 2)) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b%0d_result: got valid=%b sh=%h tag=%h expected valid=1 sh=%h tag=%h",
                             c - 2, out_valid, out_sh, out_tag, exps[c-2], 4'(c - 2));
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [31:0] exps [8] = '{32'h8000_0000, 32'hC000_0000, 32'hE000_0000, 32'hF000_0000,
                                  32'hF800_0000, 32'hFC00_0000, 32'hFE00_0000, 32'hFF00_0000};
        int got = 0;
        fork
            begin : driver
                for (int i = 0; i < 8; i++) begin
                    int stall = 0;
                    drive_op(32'h8000_0000, 5'(i), SH_SRA, 4'(i));
                    forever begin
                        @(negedge clk);
                        if (in_ready === 1'b1) break;
                        stall++;
                        if (stall > 100) break;
                        @(posedge clk); #1;
                    end
                    if (stall > 100) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL stream_accept_timeout: op %0d not accepted", i);
                        break;
                    end
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin : monitor
                logic        held_v = 1'b0;
                logic [31:0] held_sh = '0;
                logic [3:0]  held_tag = '0;
                for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
                    @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (held_v) begin
                        tests_run++;
                        if (out_valid !== 1'b1 || out_sh !== held_sh || out_tag !== held_tag) begin
                            tests_failed++;
                            $display("[TB] FAIL stream_hold: got valid=%b sh=%h tag=%h expected valid=1 sh=%h tag=%h",
                                     out_valid, out_sh, out_tag, held_sh, held_tag);
                        end
                    end
                    if (out_valid === 1'b1 && out_ready) begin
                        tests_run++;
                        if (out_sh !== exps[got] || out_tag !== 4'(got)) begin
                            tests_failed++;
                            $display("[TB] FAIL stream%0d_result: got sh=%h tag=%h expected sh=%h tag=%h",
                                     got, out_sh, out_tag, exps[got], 4'(got));
                        end
                        got++;
                        held_v = 1'b0;
                    end else if (out_valid === 1'b1) begin
                        held_v   = 1'b1;
                        held_sh  = out_sh;
                        held_tag = out_tag;
                    end else begin
                        held_v = 1'b0;
                    end
                end
                out_ready = 1'b1;
            end
        join
        tests_run++;
        if (got != 8) begin
            tests_failed++;
            $display("[TB] FAIL stream_count: got %0d results expected 8", got);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stream_drained: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_op(32'h0000_0001, 5'd4, SH_SLL, 4'd1);
        @(posedge clk); #1 drive_op(32'h0000_0002, 5'd4, SH_SLL, 4'd2);
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_pre: got busy=%b valid=%b expected 1 1", busy, out_valid);
        end
        flush = 1'b1;
        drive_op(32'h0000_0003, 5'd4, SH_SLL, 4'd3);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_cleared: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL flush_quiet%0d: got valid=%b expected 0", c, out_valid);
            end
        end
        flush = 1'b1;
        drive_op(32'h0000_0004, 5'd1, SH_SLL, 4'd4);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_same_cycle_busy: got %b expected 0", busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_same_cycle_valid: got %b expected 0", out_valid);
        end
        drive_op(32'h0000_00F0, 5'd4, SH_SRL, 4'd3);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_sh !== 32'h0000_000F || out_tag !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL flush_next_op: got valid=%b sh=%h tag=%h expected valid=1 sh=0000000f tag=3",
                     out_valid, out_sh, out_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive_op(32'h1234_0000, 5'd16, SH_SRL, 4'd4);
        @(posedge clk); #1 drive_op(32'h0000_0001, 5'd2, SH_SLL, 4'd5);
        @(posedge clk); #1 in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_sh !== 32'h0000_1234 || out_tag !== 4'd4) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_pre: got valid=%b sh=%h tag=%h expected valid=1 sh=00001234 tag=4",
                     out_valid, out_sh, out_tag);
        end
        #2 clrn = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_sh !== 32'h0 || out_tag !== 4'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rstmid_async: got valid=%b sh=%h tag=%h busy=%b expected all 0",
                     out_valid, out_sh, out_tag, busy);
        end
        @(posedge clk); #1 clrn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rstmid_quiet%0d: got valid=%b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_wide();
        logic [63:0] exp;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            w_in_valid = 1'($urandom_range(0, 1));
            w_in_x     = {$urandom(), $urandom()};
            w_in_sa    = 6'($urandom_range(0, 63));
            w_in_op    = 2'($urandom_range(0, 3));
            w_in_tag   = 4'($urandom_range(0, 15));
            if (i == 0) w_in_sa = 6'd0;
            if (i == 1) begin
                w_in_x  = 64'h8000_0000_0000_0001;
                w_in_sa = 6'd63;
                w_in_op = SH_SRA;
            end
            if (i == 2) begin
                w_in_x  = 64'h0000_0000_0000_0001;
                w_in_sa = 6'd63;
                w_in_op = SH_SLL;
            end
            exp = model64(w_in_x, w_in_sa, w_in_op);
            #1;
            tests_run++;
            if (w_out_valid !== w_in_valid || w_out_sh !== exp || w_out_tag !== w_in_tag) begin
                tests_failed++;
                $display("[TB] FAIL wide%0d: got valid=%b sh=%h tag=%h expected valid=%b sh=%h tag=%h",
                         i, w_out_valid, w_out_sh, w_out_tag, w_in_valid, exp, w_in_tag);
            end
        end
        w_in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stream();
        test_flush();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
